alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised multi-cycle signed ALU; successor to the fixed 16-bit start/done ALU.
- Adds width parameter, iterative shift-add multiplier and restoring divider, remainder and high-product modes, busy/overflow/divide-by-zero status.
- Sits between the CPU control unit and the register file; control pulses start and waits for done.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- opcode  in  3  000 ADD, 001 SUB, 010 MUL (low half), 011 DIV, 100 REM, 101 MULH (high half), 110/111 illegal.
- A  in  WIDTH  signed operand, latched on accepted start.
- B  in  WIDTH  signed operand, latched on accepted start.
- result  out  WIDTH  signed result; held from done until the next done.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- ovf  out  1  signed overflow; valid with result, held like result.
- dbz  out  1  divide by zero; valid with result, held like result.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; result=0, done=0, busy=0, ovf=0, dbz=0. Applies mid-operation: the in-flight op is aborted, no done is issued, the counter and internal registers are cleared.
- States: IDLE, MULT, DIVD, FIX, DONE.
  - IDLE: start=1 at edge E0 latches opcode, A and B.
    - ADD, SUB, illegal opcode, and DIV/REM with B=0 go to DONE.
    - MUL/MULH go to MULT.
    - DIV/REM go to DIVD.
  - MULT: loads |A|, |B| into a 2*WIDTH accumulator, then runs WIDTH shift-add iterations (one per cycle), then goes to FIX.
  - DIVD: runs WIDTH restoring iterations on |A|/|B| (one per cycle), then goes to FIX.
  - FIX: applies the sign and computes flags, then goes to DONE.
  - DONE: drives done=1 for exactly one cycle, updates result/ovf/dbz, then returns to IDLE.
- Latency, with done high in the cycle after edge En:
  - ADD/SUB/illegal/dbz: n=1.
  - MUL/MULH/DIV/REM: n=WIDTH+2.
- Back-to-back: a new start is accepted in the cycle after done (IDLE). start while busy is ignored, with no queuing, and A/B/opcode changes while busy have no effect.
- Arithmetic:
  - ADD/SUB: wrap modulo 2^WIDTH. ovf=1 on signed overflow (operand signs are equal and the result sign differs, for SUB after negating B).
  - MUL: result = low WIDTH bits of the full signed 2*WIDTH product. ovf=1 if the product does not fit in WIDTH signed bits.
  - MULH: result = high WIDTH bits of the product; ovf=0.
  - DIV: quotient truncates toward zero. A=MIN, B=-1 gives result=MIN, ovf=1.
  - REM: remainder takes the sign of A, with A = q*B + r. A=MIN, B=-1 gives 0, ovf=0.
  - B=0, DIV: result = all ones (-1), dbz=1. B=0, REM: result = A, dbz=1. ovf=0 in both cases.
  - Illegal opcode: result=0, ovf=0, dbz=0.
- ovf and dbz are cleared on every done that does not set them.
- Results must match Verilog signed +, -, *, /, % truncated to WIDTH for all non-boundary cases.

Test Plan (WIDTH=16):
- ADD A=-1200, B=-90 -> result=-1290, ovf=0, done high in the cycle after E0+1; SUB A=32767, B=-1 -> result=-32768, ovf=1.
- MUL A=800, B=570 -> result=-2752, ovf=1, done after E0+18; MULH on the same operands -> 6; MUL A=-200, B=-90 -> 18000, ovf=0.
- DIV A=-1200, B=-90 -> 13; REM -> -30; DIV A=-32768, B=-1 -> -32768, ovf=1.
- DIV A=5, B=0 -> -1, dbz=1, latency 1; REM A=5, B=0 -> 5, dbz=1; then ADD 1+1 -> 2 with dbz cleared.
- Start MUL 800*570, pulse start with DIV 7/2 at E0+5 -> ignored, a single done with the MUL result; DIV 7/2 issued the cycle after done -> 3.
- Start DIV, assert reset at E0+6 for one cycle -> no done, all outputs 0, busy=0; next ADD 3+4 -> 7 with normal latency.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle between the CPU control unit and the multi-cycle ALU.
// The control unit is the master: it raises start with operands and waits for done.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic                    start;
    logic [2:0]              opcode;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic signed [WIDTH-1:0] result;
    logic                    done;
    logic                    busy;
    logic                    ovf;
    logic                    dbz;

    modport master (
        output start, opcode, A, B,
        input  result, done, busy, ovf, dbz
    );

    modport slave (
        input  start, opcode, A, B,
        output result, done, busy, ovf, dbz
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle signed ALU: single-cycle add/sub, shift-add multiply and restoring divide on
// operand magnitudes, with the sign and overflow/divide-by-zero flags applied in a fix-up cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);
    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpMul  = 3'd2;
    localparam logic [2:0] OpDiv  = 3'd3;
    localparam logic [2:0] OpRem  = 3'd4;
    localparam logic [2:0] OpMulh = 3'd5;

    typedef enum logic [2:0] {StIdle, StMult, StDivd, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   am_q, am_d, bm_q, bm_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   pres_q, pres_d;
    logic               povf_q, povf_d, pdbz_q, pdbz_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d, busy_q, busy_d, ovf_q, ovf_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]   in_a, in_b, in_am, in_bm, sum, dif;
    logic               add_ovf, sub_ovf;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_sh, div_next, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic               neg, mul_ovf, min_neg1, last_iter;

    assign in_a    = bus.A;
    assign in_b    = bus.B;
    assign in_am   = in_a[WIDTH-1] ? -in_a : in_a;
    assign in_bm   = in_b[WIDTH-1] ? -in_b : in_b;
    assign sum     = in_a + in_b;
    assign dif     = in_a - in_b;
    assign add_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    assign sub_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (dif[WIDTH-1] != in_a[WIDTH-1]);

    // Multiply: {carry, high half} accumulates |A| while |B| shifts out of the low half.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, am_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: partial remainder in the high half, dividend/quotient bits in the low half.
    assign div_sh    = {acc_q[2*WIDTH-2:0], 1'b0};
    assign div_trial = {1'b0, div_sh[2*WIDTH-1:WIDTH]} - {1'b0, bm_q};
    assign div_next  = div_trial[WIDTH] ? div_sh
                                        : {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

    assign neg       = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    assign prod_s    = neg ? -acc_q : acc_q;
    assign quo_s     = neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_s     = a_q[WIDTH-1] ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign mul_ovf   = !(&prod_s[2*WIDTH-1:WIDTH-1]) && (|prod_s[2*WIDTH-1:WIDTH-1]);
    assign min_neg1  = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        am_d     = am_q;
        bm_d     = bm_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pres_d   = pres_q;
        povf_d   = povf_q;
        pdbz_d   = pdbz_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // busy_q is still high during the done cycle, so starts there are ignored.
                if (bus.start && !busy_q) begin
                    op_d    = bus.opcode;
                    a_d     = in_a;
                    b_d     = in_b;
                    am_d    = in_am;
                    bm_d    = in_bm;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    pres_d  = '0;
                    povf_d  = 1'b0;
                    pdbz_d  = 1'b0;
                    state_d = StDone;
                    case (bus.opcode)
                        OpAdd: begin
                            pres_d = sum;
                            povf_d = add_ovf;
                        end
                        OpSub: begin
                            pres_d = dif;
                            povf_d = sub_ovf;
                        end
                        OpMul, OpMulh: begin
                            acc_d   = {{WIDTH{1'b0}}, in_bm};
                            state_d = StMult;
                        end
                        OpDiv, OpRem: begin
                            if (in_b == '0) begin
                                pres_d = (bus.opcode == OpDiv) ? '1 : in_a;
                                pdbz_d = 1'b1;
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, in_am};
                                state_d = StDivd;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    busy_d = 1'b0;
                end
            end
            StMult: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = StFix;
            end
            StDivd: begin
                acc_d = div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = StFix;
            end
            StFix: begin
                pdbz_d = 1'b0;
                povf_d = 1'b0;
                case (op_q)
                    OpMul: begin
                        pres_d = prod_s[WIDTH-1:0];
                        povf_d = mul_ovf;
                    end
                    OpMulh: pres_d = prod_s[2*WIDTH-1:WIDTH];
                    OpDiv: begin
                        pres_d = quo_s;
                        povf_d = min_neg1;
                    end
                    default: pres_d = rem_s;
                endcase
                state_d = StDone;
            end
            StDone: begin
                result_d = pres_q;
                ovf_d    = povf_q;
                dbz_d    = pdbz_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            am_q     <= '0;
            bm_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pres_q   <= '0;
            povf_q   <= 1'b0;
            pdbz_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            am_q     <= am_d;
            bm_q     <= bm_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pres_q   <= pres_d;
            povf_q   <= povf_d;
            pdbz_q   <= pdbz_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.ovf    = ovf_q;
    assign bus.dbz    = dbz_q;
endmodule
